mem_responder: RTL and testbench
================================

// Module: mem_responder
// PURPOSE
//   Memory target that answers exec_unit load/store/fetch requests over a valid/ready
//   request channel and a valid/ready response channel. It sits between exec_unit and
//   its storage and replaces the free-running array.
//   Programmable wait states model slow memory.
//   The storage array is named memory[0:DEPTH-1] so benches can preload it by backdoor.
// PARAMETERS
//   DATA_BITS    8    word width
//   ADDR_BITS    8    request address width
//   DEPTH        256  words of storage; must satisfy DEPTH <= 2**ADDR_BITS (elaboration $error otherwise)
//   WAIT_STATES  1    extra cycles between request accept and response valid; range 0..15
// PORTS
//   clk        in   1          rising-edge clock
//   reset      in   1          asynchronous, active-high reset
//   req_valid  in   1          request present
//   req_ready  out  1          responder can accept a request
//   req_write  in   1          1 = store, 0 = load
//   req_addr   in   ADDR_BITS  word address
//   req_wdata  in   DATA_BITS  store data
//   rsp_valid  out  1          response present
//   rsp_ready  in   1          requester takes the response
//   rsp_rdata  out  DATA_BITS  load data; for a store, the old contents at the address
//   rsp_err    out  1          address error (see CONFIGURATION)
//   busy       out  1          state != IDLE
// BEHAVIOUR
// - FSM states: IDLE, WAIT, RESP. Registers: state, wait_cnt[3:0], rsp_rdata, rsp_err.
// - Reset (asynchronous, takes effect immediately):
//   - state = IDLE, wait_cnt = 0, rsp_rdata = 0, rsp_err = 0.
//   - Resulting outputs: req_ready = 1, rsp_valid = 0, busy = 0.
//   - memory[] is never cleared by reset, so backdoor preload survives reset.
// - Decoded outputs: req_ready = (state==IDLE); rsp_valid = (state==RESP);
//   busy = (state!=IDLE). All are decoded from state only, with no combinational path from inputs.
// - Accept: the rising edge where req_valid && req_ready (IDLE only). On that same edge:
//   - rsp_rdata <= memory[idx], always the old value (read-before-write).
//   - If req_write, memory[idx] <= req_wdata.
//   - If WAIT_STATES == 0: go to RESP. Otherwise wait_cnt <= WAIT_STATES and go to WAIT.
// - WAIT: wait_cnt decrements each edge. The edge where wait_cnt == 1 moves to RESP.
// - Latency: rsp_valid rises 1 + WAIT_STATES cycles after the accept edge.
// - RESP: rsp_valid = 1. rsp_rdata and rsp_err hold stable until the edge with rsp_ready = 1,
//   which returns the FSM to IDLE.
//   - req_valid is ignored during WAIT and RESP (req_ready = 0). The requester must hold the request.
//   - There is no accept in the same cycle as a response handshake.
//   - Peak throughput: 1 transaction per 2 + WAIT_STATES cycles.
// - Index: idx = req_addr mod DEPTH. If DEPTH is a power of two, idx is the low address bits.
// - Reset during WAIT or RESP aborts the transaction and drops the response.
//   A store performed at accept stays in memory.
// - Simultaneous reset and accept: reset wins; no memory write occurs.
// CONFIGURATION
//   MEM_RANGE_CHECK_EN defined:
//     - At accept, if req_addr >= DEPTH: no memory write, rsp_rdata <= 0, rsp_err <= 1.
//     - Latency and handshake are unchanged.
//     - In-range accesses set rsp_err <= 0.
//   MEM_RANGE_CHECK_EN undefined:
//     - Out-of-range addresses wrap to req_addr mod DEPTH.
//     - rsp_err is a constant 0; the port is still present.
// TESTING
// - Preload memory[i]=i, WAIT_STATES=1. Reset, then load addr 0x05, rsp_ready=1:
//   rsp_valid high on the 2nd cycle after accept with rsp_rdata=0x05, then IDLE on the next edge.
// - Store 0xA5 to addr 0x10 -> response rsp_rdata=0x10 (old value). Then load 0x10 -> rsp_rdata=0xA5.
// - Backpressure: hold rsp_ready=0 for 3 cycles during RESP ->
//   rsp_valid and rsp_rdata stay stable, req_ready=0, and a new req_valid is not accepted.
// - Assert reset in WAIT (after a store of 0x3C to 0x20) -> rsp_valid=0 and req_ready=1 immediately.
//   A later load of 0x20 returns 0x3C.
// - DEPTH=128, load addr 0x85:
//   - Without the macro: rsp_rdata=0x05, rsp_err=0.
//   - With MEM_RANGE_CHECK_EN: rsp_rdata=0, rsp_err=1, and a store to 0x85 leaves memory[5] unchanged.
// - WAIT_STATES=0, rsp_ready tied 1, req_valid held 1 -> rsp_valid one cycle after each accept.
//   Accepts occur every 2 cycles; 4 loads of 0..3 return 0,1,2,3 in order.

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder: valid/ready memory target with programmable wait states.
// Define MEM_RANGE_CHECK_EN to flag out-of-range addresses instead of wrapping.
module mem_responder #(
  parameter int DATA_BITS   = 8,
  parameter int ADDR_BITS   = 8,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [ADDR_BITS-1:0] req_addr,
  input  logic [DATA_BITS-1:0] req_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DATA_BITS-1:0] rsp_rdata,
  output logic                 rsp_err,
  output logic                 busy
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [3:0]           r_wait_cnt;
  logic [DATA_BITS-1:0] r_rdata;
  logic                 r_err;
  logic [DATA_BITS-1:0] memory [0:DEPTH-1];

  logic                 w_accept;
  logic                 w_oob;
  logic                 w_we;
  logic [IW-1:0]        w_idx;

  generate
    if (DEPTH > 2**ADDR_BITS) begin : g_depth_chk
      $error("mem_responder: DEPTH exceeds 2**ADDR_BITS");
    end
    if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_ws_chk
      $error("mem_responder: WAIT_STATES out of 0..15");
    end
  endgenerate

  // Wrapped word index; low address bits when DEPTH is a power of two.
  assign w_idx = IW'(32'(req_addr) % 32'(DEPTH));

`ifdef MEM_RANGE_CHECK_EN
  assign w_oob = (32'(req_addr) >= 32'(DEPTH));
`else
  assign w_oob = 1'b0;
`endif

  assign w_accept = req_valid && (r_state == S_IDLE);
  assign w_we     = w_accept && req_write && !w_oob;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: if (req_valid)
                w_state_nxt = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
      S_WAIT: if (r_wait_cnt <= 4'd1)
                w_state_nxt = S_RESP;
      S_RESP: if (rsp_ready)
                w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Capture old contents at accept, count down wait states.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wait_cnt <= 4'd0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
    end else if (w_accept) begin
      r_rdata    <= w_oob ? '0 : memory[w_idx];
      r_err      <= w_oob;
      r_wait_cnt <= 4'(WAIT_STATES);
    end else if (r_state == S_WAIT) begin
      r_wait_cnt <= r_wait_cnt - 4'd1;
    end
  end

  // Storage write; reset blocks a coincident store, contents never cleared.
  always_ff @(posedge clk or posedge reset) begin
    if (!reset && w_we) memory[w_idx] <= req_wdata;
  end

  assign req_ready = (r_state == S_IDLE);
  assign rsp_valid = (r_state == S_RESP);
  assign busy      = (r_state != S_IDLE);
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: scoreboard bench for three mem_responder configurations.
// u0: default, u1: DEPTH=128, u2: WAIT_STATES=0.
module tb_mem_responder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       v   [3];
  logic       w   [3];
  logic [7:0] a   [3];
  logic [7:0] wd  [3];
  logic       rr  [3];
  logic       rdy [3];
  logic       rv  [3];
  logic [7:0] rd  [3];
  logic       er  [3];
  logic       bz  [3];

  logic [7:0] mdl [0:2][0:255];
  logic [8:0] sbq [$];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_responder #(.DEPTH(256), .WAIT_STATES(1)) u0 (
    .clk(clk), .reset(reset),
    .req_valid(v[0]), .req_ready(rdy[0]), .req_write(w[0]),
    .req_addr(a[0]), .req_wdata(wd[0]),
    .rsp_valid(rv[0]), .rsp_ready(rr[0]),
    .rsp_rdata(rd[0]), .rsp_err(er[0]), .busy(bz[0])
  );

  mem_responder #(.DEPTH(128), .WAIT_STATES(1)) u1 (
    .clk(clk), .reset(reset),
    .req_valid(v[1]), .req_ready(rdy[1]), .req_write(w[1]),
    .req_addr(a[1]), .req_wdata(wd[1]),
    .rsp_valid(rv[1]), .rsp_ready(rr[1]),
    .rsp_rdata(rd[1]), .rsp_err(er[1]), .busy(bz[1])
  );

  mem_responder #(.DEPTH(256), .WAIT_STATES(0)) u2 (
    .clk(clk), .reset(reset),
    .req_valid(v[2]), .req_ready(rdy[2]), .req_write(w[2]),
    .req_addr(a[2]), .req_wdata(wd[2]),
    .rsp_valid(rv[2]), .rsp_ready(rr[2]),
    .rsp_rdata(rd[2]), .rsp_err(er[2]), .busy(bz[2])
  );

  task automatic txn(input int k, input logic wr,
                     input logic [7:0] addr, input logic [7:0] wdat);
    int dep, ws, idx, n;
    logic oob;
    logic [8:0] e;
    dep = (k == 1) ? 128 : 256;
    ws  = (k == 2) ? 0 : 1;
    idx = int'(addr) % dep;
`ifdef MEM_RANGE_CHECK_EN
    oob = (int'(addr) >= dep);
`else
    oob = 1'b0;
`endif
    if (oob) e = 9'h100;
    else begin
      e = {1'b0, mdl[k][idx]};
      if (wr) mdl[k][idx] = wdat;
    end
    sbq.push_back(e);
    @(negedge clk);
    total++;
    if (rdy[k] !== 1'b1) begin
      bad++;
      $display("FAIL ready_idle u%0d got=%b exp=1", k, rdy[k]);
    end
    v[k] = 1'b1; w[k] = wr; a[k] = addr; wd[k] = wdat;
    @(negedge clk);
    v[k] = 1'b0;
    n = 1;
    while (rv[k] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n != ws + 1) begin
      bad++;
      $display("FAIL latency u%0d addr=%h got=%0d exp=%0d", k, addr, n, ws + 1);
    end
    e = sbq.pop_front();
    total++;
    if ({er[k], rd[k]} !== e) begin
      bad++;
      $display("FAIL rsp u%0d addr=%h got=%h/%b exp=%h/%b",
               k, addr, rd[k], er[k], e[7:0], e[8]);
    end
    @(negedge clk);
    total++;
    if (rdy[k] !== 1'b1 || rv[k] !== 1'b0) begin
      bad++;
      $display("FAIL back_idle u%0d got=%b%b exp=10", k, rdy[k], rv[k]);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      total++;
      if ({rdy[k], rv[k], bz[k], er[k], rd[k]} !== {4'b1000, 8'h00}) begin
        bad++;
        $display("FAIL reset u%0d got=%b%b%b%b/%h exp=1000/00",
                 k, rdy[k], rv[k], bz[k], er[k], rd[k]);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_load_store();
    txn(0, 1'b0, 8'h05, 8'h00);
    txn(0, 1'b1, 8'h10, 8'hA5);
    txn(0, 1'b0, 8'h10, 8'h00);
    txn(0, 1'b1, 8'hFF, 8'h5A);
    txn(0, 1'b0, 8'hFF, 8'h00);
  endtask

  task automatic test_backpressure();
    logic [8:0] e;
    int n;
    e = {1'b0, mdl[0][8'h30]};
    sbq.push_back(e);
    @(negedge clk);
    rr[0] = 1'b0;
    v[0] = 1'b1; w[0] = 1'b0; a[0] = 8'h30;
    @(negedge clk);
    v[0] = 1'b0;
    n = 0;
    while (rv[0] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    e = sbq.pop_front();
    total++;
    if ({er[0], rd[0]} !== e) begin
      bad++;
      $display("FAIL bp_rsp got=%h exp=%h", rd[0], e[7:0]);
    end
    for (int i = 0; i < 3; i++) begin
      v[0] = 1'b1; w[0] = 1'b1; a[0] = 8'h31; wd[0] = 8'hEE;
      @(negedge clk);
      total++;
      if ({rv[0], rdy[0], bz[0], rd[0]} !== {3'b101, e[7:0]}) begin
        bad++;
        $display("FAIL bp_hold cyc%0d got=%b%b%b/%h exp=101/%h",
                 i, rv[0], rdy[0], bz[0], rd[0], e[7:0]);
      end
    end
    v[0] = 1'b0;
    rr[0] = 1'b1;
    @(negedge clk);
    total++;
    if (rdy[0] !== 1'b1 || rv[0] !== 1'b0) begin
      bad++;
      $display("FAIL bp_release got=%b%b exp=10", rdy[0], rv[0]);
    end
    txn(0, 1'b0, 8'h31, 8'h00);
  endtask

  task automatic test_reset_in_wait();
    @(negedge clk);
    v[0] = 1'b1; w[0] = 1'b1; a[0] = 8'h20; wd[0] = 8'h3C;
    @(negedge clk);
    v[0] = 1'b0;
    total++;
    if (bz[0] !== 1'b1 || rv[0] !== 1'b0) begin
      bad++;
      $display("FAIL in_wait got=%b%b exp=10", bz[0], rv[0]);
    end
    reset = 1'b1;
    #1;
    total++;
    if ({rv[0], rdy[0], bz[0]} !== 3'b010) begin
      bad++;
      $display("FAIL abort got=%b%b%b exp=010", rv[0], rdy[0], bz[0]);
    end
    mdl[0][8'h20] = 8'h3C;
    @(negedge clk);
    reset = 1'b0;
    txn(0, 1'b0, 8'h20, 8'h00);
  endtask

  task automatic test_reset_vs_accept();
    @(negedge clk);
    reset = 1'b1;
    v[0] = 1'b1; w[0] = 1'b1; a[0] = 8'h40; wd[0] = 8'h77;
    @(negedge clk);
    v[0] = 1'b0;
    reset = 1'b0;
    txn(0, 1'b0, 8'h40, 8'h00);
  endtask

  task automatic test_depth128();
    txn(1, 1'b0, 8'h85, 8'h00);
    txn(1, 1'b0, 8'h7F, 8'h00);
    txn(1, 1'b1, 8'h85, 8'h99);
    txn(1, 1'b0, 8'h05, 8'h00);
  endtask

  task automatic test_back_to_back();
    int issued, got, last_acc, cyc;
    logic [8:0] e;
    issued = 0; got = 0; last_acc = -10; cyc = 0;
    @(negedge clk);
    while (cyc < 30 && !(got == 4 && issued == 4)) begin
      if (rv[2] === 1'b1) begin
        e = sbq.pop_front();
        total++;
        if ({er[2], rd[2]} !== e || cyc - last_acc != 1) begin
          bad++;
          $display("FAIL b2b_rsp n%0d got=%h dly=%0d exp=%h dly=1",
                   got, rd[2], cyc - last_acc, e[7:0]);
        end
        got++;
      end
      if (rdy[2] === 1'b1 && issued < 4) begin
        if (issued > 0) begin
          total++;
          if (cyc - last_acc != 2) begin
            bad++;
            $display("FAIL b2b_spacing got=%0d exp=2", cyc - last_acc);
          end
        end
        v[2] = 1'b1; w[2] = 1'b0; a[2] = 8'(issued);
        sbq.push_back({1'b0, mdl[2][issued]});
        last_acc = cyc;
        issued++;
      end
      @(negedge clk);
      cyc++;
    end
    v[2] = 1'b0;
    total++;
    if (got != 4) begin
      bad++;
      $display("FAIL b2b_count got=%0d exp=4", got);
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      v[k] = 1'b0; w[k] = 1'b0; a[k] = 8'h00; wd[k] = 8'h00; rr[k] = 1'b1;
    end
    for (int i = 0; i < 256; i++) begin
      u0.memory[i] = 8'(i);
      u2.memory[i] = 8'(i);
      mdl[0][i] = 8'(i);
      mdl[1][i] = 8'(i % 128);
      mdl[2][i] = 8'(i);
    end
    for (int i = 0; i < 128; i++) u1.memory[i] = 8'(i);
    test_reset();
    test_load_store();
    test_backpressure();
    test_reset_in_wait();
    test_reset_vs_accept();
    test_depth128();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
